// File: rtl/lfsr_range_rng.sv
// Fibonacci LFSR random source with a raw tap-off and a request port that
// reduces a captured sample into [RANGE_LO, RANGE_LO+RANGE_SPAN-1] by repeated subtraction.
// Optional feature: define RNG_REQ_ADVANCE_EN to make every accepted request step the LFSR.
module lfsr_range_rng #(
  parameter int                LFSR_W     = 21,
  parameter int                TAP_A      = 20,
  parameter int                TAP_B      = 18,
  parameter logic [LFSR_W-1:0] SEED       = 21'h1FFFFF,
  parameter int                OUT_W      = 8,
  parameter int                RANGE_LO   = 40,
  parameter int                RANGE_SPAN = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [OUT_W-1:0]  raw_out,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  value
);

  // One extra bit so a span of exactly 2^OUT_W is representable.
  localparam logic [OUT_W:0]   SPAN_C = (OUT_W+1)'(RANGE_SPAN);
  localparam logic [OUT_W-1:0] LO_C   = OUT_W'(RANGE_LO);

  typedef enum logic {IDLE, REDUCE} state_t;

  state_t              state, state_d;
  logic [LFSR_W-1:0]   lfsr, lfsr_d, lfsr_step;
  logic [OUT_W-1:0]    acc, acc_d, value_d;
  logic                busy_d, valid_d, accept, adv;

  assign lfsr_step = {lfsr[LFSR_W-2:0], lfsr[TAP_A] ^ lfsr[TAP_B]};
  assign accept    = (state == IDLE) && req;

`ifdef RNG_REQ_ADVANCE_EN
  assign adv = en | accept;
`else
  assign adv = en;
`endif

  // Reseed beats lockup recovery beats stepping; zero is never a legal state.
  always_comb begin
    lfsr_d = lfsr;
    if (seed_load)
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    else if (lfsr == '0)
      lfsr_d = SEED;
    else if (adv)
      lfsr_d = lfsr_step;
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    busy_d  = busy;
    valid_d = 1'b0;
    value_d = value;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_d   = lfsr[OUT_W-1:0];
          busy_d  = 1'b1;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if ({1'b0, acc} >= SPAN_C) begin
          acc_d = acc - SPAN_C[OUT_W-1:0];
        end else begin
          value_d = acc + LO_C;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= SEED;
      raw_out <= '0;
      state   <= IDLE;
      acc     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      value   <= '0;
    end else begin
      lfsr    <= lfsr_d;
      raw_out <= lfsr[OUT_W-1:0];
      state   <= state_d;
      acc     <= acc_d;
      busy    <= busy_d;
      valid   <= valid_d;
      value   <= value_d;
    end
  end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Self-checking bench for lfsr_range_rng: directed scenarios plus a randomized run
// compared against a transaction-level model (modulo arithmetic, edge countdown).
module tb_lfsr_range_rng;
  localparam int          LFSR_W = 21, TAP_A = 20, TAP_B = 18, OUT_W = 8;
  localparam int          LO = 40, SPAN = 120;
  localparam int unsigned SEED_V = 32'h1FFFFF;
  localparam int unsigned MASK   = (32'd1 << LFSR_W) - 1;
`ifdef RNG_REQ_ADVANCE_EN
  localparam bit ADV = 1'b1;
`else
  localparam bit ADV = 1'b0;
`endif

  logic              clk = 0, rst = 1, en = 0, seed_load = 0, req = 0;
  logic [LFSR_W-1:0] seed_in = '0;
  logic [OUT_W-1:0]  raw_out, value;
  logic              busy, valid;

  lfsr_range_rng dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .raw_out(raw_out), .req(req), .busy(busy), .valid(valid), .value(value)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Reference model: LFSR as an integer, request as "edges left" + precomputed result.
  int unsigned m_lfsr, m_raw, m_value, m_pend, m_left;
  bit          m_busy, m_valid;

  function automatic int unsigned next_lfsr(input int unsigned s);
    return ((s << 1) & MASK) | (((s >> TAP_A) ^ (s >> TAP_B)) & 1);
  endfunction

  task automatic model_reset();
    m_lfsr = SEED_V; m_raw = 0; m_value = 0; m_pend = 0; m_left = 0;
    m_busy = 0; m_valid = 0;
  endtask

  task automatic do_reset();
    en = 0; seed_load = 0; seed_in = '0; req = 0;
    rst = 1; model_reset();
    @(posedge clk); #1 rst = 0;
  endtask

  // Drive one edge worth of inputs and advance the model by one edge.
  task automatic cyc(input bit e, input bit sl, input int unsigned si, input bit rq);
    bit          took;
    int unsigned samp;
    en = e; seed_load = sl; seed_in = si[LFSR_W-1:0]; req = rq;
    @(posedge clk);
    took  = !m_busy && rq;
    m_raw = m_lfsr % 256;
    if (m_busy) begin
      m_left--;
      m_valid = (m_left == 0);
      if (m_valid) begin m_value = m_pend; m_busy = 0; end
    end else begin
      m_valid = 0;
      if (rq) begin
        samp   = m_lfsr % 256;
        m_busy = 1;
        m_left = samp / SPAN + 1;
        m_pend = samp % SPAN + LO;
      end
    end
    if (sl)                     m_lfsr = ((si & MASK) == 0) ? SEED_V : (si & MASK);
    else if (m_lfsr == 0)       m_lfsr = SEED_V;
    else if (e || (ADV && took)) m_lfsr = next_lfsr(m_lfsr);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (raw_out !== 8'h00) begin errs++; $display("FAIL reset_raw: got %0h want 0", raw_out); end
    if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (valid !== 1'b0)    begin errs++; $display("FAIL reset_valid: got %0b want 0", valid); end
    if (value !== 8'h00)   begin errs++; $display("FAIL reset_value: got %0h want 0", value); end
  endtask

  task automatic test_lfsr_step();
    logic [7:0] exp_raw [3];
    exp_raw = '{8'hFF, 8'hFE, 8'hFC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (raw_out !== exp_raw[i]) begin errs++; $display("FAIL step_raw%0d: got %0h want %0h", i, raw_out, exp_raw[i]); end
    end
  endtask

  task automatic test_range_basic();
    do_reset();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (busy !== 1'b1)  begin errs++; $display("FAIL basic_busy%0d: got %0b want 1", i, busy); end
      if (valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid%0d: got %0b want 0", i, valid); end
      if (i < 2) cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0);
    checks += 3;
    if (valid !== 1'b1)  begin errs++; $display("FAIL basic_valid: got %0b want 1", valid); end
    if (value !== 8'd55) begin errs++; $display("FAIL basic_value: got %0d want 55", value); end
    if (busy !== 1'b0)   begin errs++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    cyc(0, 0, 0, 0);
    checks += 2;
    if (valid !== 1'b0)  begin errs++; $display("FAIL basic_pulse: got %0b want 0", valid); end
    if (value !== 8'd55) begin errs++; $display("FAIL basic_hold: got %0d want 55", value); end
  endtask

  task automatic test_seed_load();
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);          // lfsr now 0x1FFFF8
    cyc(0, 1, 0, 0);                     // zero seed -> SEED
    cyc(0, 0, 0, 0);
    checks++;
    if (raw_out !== 8'hFF) begin errs++; $display("FAIL seed_zero: got %0h want ff", raw_out); end
    cyc(1, 1, 32'h000123, 0);            // load beats enable
    cyc(1, 0, 0, 0);
    checks++;
    if (raw_out !== 8'h23) begin errs++; $display("FAIL seed_load: got %0h want 23", raw_out); end
    cyc(0, 0, 0, 0);
    checks++;
    if (raw_out !== 8'h46) begin errs++; $display("FAIL seed_step: got %0h want 46", raw_out); end
  endtask

  task automatic test_busy_abort();
    int nvalid = 0;
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(1, 1, 32'h0ABCDE, 1);            // req/reseed/en while busy must not disturb the sample
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    checks += 2;
    if (valid !== 1'b1)  begin errs++; $display("FAIL busy_valid: got %0b want 1", valid); end
    if (value !== 8'd55) begin errs++; $display("FAIL busy_value: got %0d want 55", value); end
    repeat (6) begin cyc(0, 0, 0, 0); if (valid === 1'b1) nvalid++; end
    checks++;
    if (nvalid != 0) begin errs++; $display("FAIL busy_extra_valid: got %0d want 0", nvalid); end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    rst = 1; model_reset();
    #1;
    checks += 3;
    if (valid !== 1'b0) begin errs++; $display("FAIL abort_valid: got %0b want 0", valid); end
    if (value !== 8'h0) begin errs++; $display("FAIL abort_value: got %0h want 0", value); end
    if (busy !== 1'b0)  begin errs++; $display("FAIL abort_busy: got %0b want 0", busy); end
    @(posedge clk); #1 rst = 0;
    nvalid = 0;
    repeat (6) begin cyc(0, 0, 0, 0); if (valid === 1'b1) nvalid++; end
    checks++;
    if (nvalid != 0) begin errs++; $display("FAIL abort_late_valid: got %0d want 0", nvalid); end
  endtask

  task automatic test_back_to_back();
    int        nv = 0;
    logic [7:0] got [2];
    logic [7:0] exp2;
    got = '{8'h0, 8'h0};
    exp2 = ADV ? 8'd54 : 8'd55;
    do_reset();
    for (int i = 0; i < 20 && nv < 2; i++) begin
      cyc(0, 0, 0, 1);
      if (valid === 1'b1) begin got[nv] = value; nv++; end
    end
    checks += 3;
    if (nv != 2)          begin errs++; $display("FAIL b2b_count: got %0d want 2", nv); end
    if (got[0] !== 8'd55) begin errs++; $display("FAIL b2b_first: got %0d want 55", got[0]); end
    if (got[1] !== exp2)  begin errs++; $display("FAIL b2b_second: got %0d want %0d", got[1], exp2); end
    req = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0,
          ($urandom_range(0, 3) == 0) ? 0 : $urandom, $urandom_range(0, 2) == 0);
      checks += 4;
      if (raw_out !== m_raw[7:0])   begin errs++; $display("FAIL rnd_raw@%0d: got %0h want %0h", i, raw_out, m_raw[7:0]); end
      if (busy !== m_busy)          begin errs++; $display("FAIL rnd_busy@%0d: got %0b want %0b", i, busy, m_busy); end
      if (valid !== m_valid)        begin errs++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, valid, m_valid); end
      if (value !== m_value[7:0])   begin errs++; $display("FAIL rnd_value@%0d: got %0h want %0h", i, value, m_value[7:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_step();
    test_range_basic();
    test_seed_load();
    test_busy_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
